// File: rtl/fbm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fbm_pkg
//  Description : Shared widths, constants and types for the block-matching
//                result link (serial frame = {coordinate[7:0], mad[11:0]}).
//  Revision    : 1.0 - initial release
// ============================================================================
package fbm_pkg;

    localparam int COORD_W = 8;
    localparam int MAD_W   = 12;
    localparam int FRAME_W = COORD_W + MAD_W;
    localparam int BCNT_W  = 5;
    localparam int FCNT_W  = 9;

    localparam logic [MAD_W-1:0] MAD_MAX = 12'hFFF;

    // Deserializer FSM encoding
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    typedef struct packed {
        logic [COORD_W-1:0] coord;
        logic [MAD_W-1:0]   mad;
    } match_t;

    // Split a completed MSB-first frame word into its fields
    function automatic match_t word_to_match(input logic [FRAME_W-1:0] word);
        match_t m;
        m.coord = word[FRAME_W-1:MAD_W];
        m.mad   = word[MAD_W-1:0];
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/best_match_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : best_match_tracker
//  Description : Keeps the minimum-MAD candidate seen since the last clear,
//                counts frames and pulses search_done every N_FRAMES frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module best_match_tracker
    import fbm_pkg::*;
#(
    parameter int N_FRAMES = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] in_coord,
    input  logic [MAD_W-1:0]   in_mad,
    output logic [COORD_W-1:0] best_coord,
    output logic [MAD_W-1:0]   best_mad,
    output logic               best_valid,
    output logic               search_done
);

    localparam logic [FCNT_W-1:0] c_N_FRAMES = FCNT_W'(N_FRAMES);

    match_t            r_best;
    logic              r_best_valid;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              r_search_done;

    match_t            w_base;
    logic              w_base_valid;
    logic [FCNT_W-1:0] w_base_cnt;
    logic [FCNT_W-1:0] w_cnt_inc;
    logic              w_take;

    // State as seen by an incoming frame: a same-cycle clear is applied first
    always_comb begin
        w_base       = r_best;
        w_base_valid = r_best_valid;
        w_base_cnt   = r_frame_cnt;
        if (clear) begin
            w_base.coord = '0;
            w_base.mad   = MAD_MAX;
            w_base_valid = 1'b0;
            w_base_cnt   = '0;
        end
        w_cnt_inc = w_base_cnt + 1'b1;
        // Strict less-than keeps the earlier candidate on a tie
        w_take    = in_valid && (!w_base_valid || (in_mad < w_base.mad));
    end

    // Best-match registers, frame counter and window-complete pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_best.coord  <= '0;
            r_best.mad    <= MAD_MAX;
            r_best_valid  <= 1'b0;
            r_frame_cnt   <= '0;
            r_search_done <= 1'b0;
        end else begin
            r_search_done <= 1'b0;
            r_best        <= w_base;
            r_best_valid  <= w_base_valid;
            r_frame_cnt   <= w_base_cnt;
            if (in_valid) begin
                if (w_take) begin
                    r_best.coord <= in_coord;
                    r_best.mad   <= in_mad;
                end
                r_best_valid <= 1'b1;
                if (w_cnt_inc == c_N_FRAMES) begin
                    r_search_done <= 1'b1;
                    r_frame_cnt   <= '0;
                end else begin
                    r_frame_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign best_coord  = r_best.coord;
    assign best_mad    = r_best.mad;
    assign best_valid  = r_best_valid;
    assign search_done = r_search_done;

endmodule
`default_nettype wire

// File: rtl/deser20.sv
`default_nettype none
// ============================================================================
//  Module      : deser20
//  Description : Receive-side deserializer for the 20-bit block-matching
//                result link. Rebuilds {coordinate, mad} frames from an
//                MSB-first serial stream and tracks the best (minimum MAD)
//                candidate across a search window.
//  Revision    : 1.0 - initial release
// ============================================================================
module deser20
    import fbm_pkg::*;
#(
    parameter int N_FRAMES = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_in_port,
    input  logic               frame_start,
    input  logic               clear,
    output logic [COORD_W-1:0] coordinate,
    output logic [MAD_W-1:0]   mad,
    output logic               out_valid,
    output logic               frame_err,
    output logic [COORD_W-1:0] best_coord,
    output logic [MAD_W-1:0]   best_mad,
    output logic               best_valid,
    output logic               search_done
);

    localparam logic [BCNT_W-1:0] c_LAST_BIT = BCNT_W'(FRAME_W - 1);

    logic [0:0]         r_state;
    // Bits captured so far; the final bit is taken straight from the pin on
    // the completing cycle, so the register never needs to hold all 20.
    logic [FRAME_W-2:0] r_sr;
    logic [BCNT_W-1:0]  r_bit_cnt;
    logic [COORD_W-1:0] r_coord;
    logic [MAD_W-1:0]   r_mad;
    logic               r_out_valid;
    logic               r_frame_err;

    logic [FRAME_W-1:0] w_word;
    match_t             w_frame;

    // Word as it stands after this cycle's capture
    assign w_word  = {r_sr, s_in_port};
    assign w_frame = word_to_match(w_word);

    // Deserializer FSM: frame alignment, shifting, and registered frame output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_coord     <= '0;
            r_mad       <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (frame_start) begin
                        r_sr      <= {{(FRAME_W-2){1'b0}}, s_in_port};
                        r_bit_cnt <= BCNT_W'(1);
                        r_state   <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (frame_start) begin
                        // Early start: drop the partial frame, this bit is a new MSB
                        r_frame_err <= 1'b1;
                        r_sr        <= {{(FRAME_W-2){1'b0}}, s_in_port};
                        r_bit_cnt   <= BCNT_W'(1);
                    end else if (r_bit_cnt == c_LAST_BIT) begin
                        r_coord     <= w_frame.coord;
                        r_mad       <= w_frame.mad;
                        r_out_valid <= 1'b1;
                        r_sr        <= '0;
                        r_bit_cnt   <= '0;
                        r_state     <= c_ST_IDLE;
                    end else begin
                        r_sr      <= w_word[FRAME_W-2:0];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign coordinate = r_coord;
    assign mad        = r_mad;
    assign out_valid  = r_out_valid;
    assign frame_err  = r_frame_err;

    best_match_tracker #(
        .N_FRAMES (N_FRAMES)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (r_out_valid),
        .in_coord    (r_coord),
        .in_mad      (r_mad),
        .best_coord  (best_coord),
        .best_mad    (best_mad),
        .best_valid  (best_valid),
        .search_done (search_done)
    );

endmodule
`default_nettype wire
